alu_op_sequencer: RTL and testbench

//  Command front-end directly upstream of the 16-bit ALU. Buffers {Opcode,X,Y} commands from the

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: ALU opcode values,
// sequencer FSM state encoding and the width of one buffered command entry.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_LT  = 3'b100;
    localparam logic [OP_W-1:0] OP_ADC = 3'b101;
    localparam logic [OP_W-1:0] OP_AND = 3'b110;
    localparam logic [OP_W-1:0] OP_ORW = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

    // One command entry is {opcode, x, y}.
    function automatic int cmd_entry_w(input int data_w);
        return OP_W + 2 * data_w;
    endfunction

    localparam int CMD_W_DEF = cmd_entry_w(16);

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO holding queued ALU commands.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   push_i       write wdata_i (ignored when full)
//   wdata_i      entry to write
//   pop_i        drop the head entry (ignored when empty)
//   rdata_o      head entry (valid when !empty_o)
//   full_o       no free entry
//   empty_o      no stored entry
// Pointers carry one extra wrap bit, so they count modulo 2*DEPTH and
// full/empty are told apart by that MSB.
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Command front-end for the 16-bit ALU. Queues {op,x,y} commands, issues one
// at a time (Enable pulse), waits ALU_LAT cycles, captures Results/CF and
// offers them on a valid/ready response port.
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready = !full)
//   cmd_op/cmd_x/cmd_y              command fields
//   alu_en/alu_op/alu_x/alu_y       drive to ALU
//   alu_res/alu_cf                  ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_data/rsp_cf                 captured Results/CF
//   busy                            FSM active or commands queued
//   ovf_cnt                         only with ALU_SEQ_OVF_CNT_EN: saturating
//                                   count of ADD/ADC responses with CF=1
// ---------------------------------------------------------------------------
// state    | meaning
// ST_IDLE  | nothing in flight; pop head of FIFO when present
// ST_ISSUE | alu_en high, wait counter loaded
// ST_WAIT  | counting down ALU latency; capture on terminal count
// ST_RESP  | response held until rsp_ready
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_x,
    input  logic [DATA_W-1:0] cmd_y,
    output logic              alu_en,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_cf,
    output logic              busy
`ifdef ALU_SEQ_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt
`endif
);

    localparam int CMD_W = cmd_entry_w(DATA_W);
    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        alu_op_q;
    logic [DATA_W-1:0] alu_x_q, alu_y_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_cf_q;
    logic              pop, capture;
    logic              fifo_full, fifo_empty;
    logic [CMD_W-1:0]  fifo_rdata;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_op, cmd_x, cmd_y}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LAT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                // Handshake edge may pop the next command directly, skipping IDLE.
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alu_op_q   <= '0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            rsp_data_q <= '0;
            rsp_cf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                alu_op_q <= fifo_rdata[CMD_W-1 -: 3];
                alu_x_q  <= fifo_rdata[2*DATA_W-1 -: DATA_W];
                alu_y_q  <= fifo_rdata[DATA_W-1:0];
            end
            if (capture) begin
                rsp_data_q <= alu_res;
                rsp_cf_q   <= alu_cf;
            end
        end
    end

`ifdef ALU_SEQ_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_cnt_q <= '0;
        end else if (capture && alu_cf && ((alu_op_q == OP_ADD) || (alu_op_q == OP_ADC))
                     && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign cmd_ready = !fifo_full;
    assign alu_en    = (state_q == ST_ISSUE);
    assign alu_op    = alu_op_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_cf    = rsp_cf_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 16;
    localparam int ALU_LAT = 1;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [DATA_W-1:0] cmd_x = '0;
    logic [DATA_W-1:0] cmd_y = '0;
    logic              alu_en;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_x, alu_y;
    logic [DATA_W-1:0] alu_res = '0;
    logic              alu_cf = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_cf;
    logic              busy;
`ifdef ALU_SEQ_OVF_CNT_EN
    logic [7:0]        ovf_cnt;
`endif

    always #5 CLK = ~CLK;

    alu_op_sequencer #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_res   (alu_res),
        .alu_cf    (alu_cf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cf    (rsp_cf),
        .busy      (busy)
`ifdef ALU_SEQ_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU behaviour, returns {cf, result}.
    function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            OP_ADD:  return {1'b0, x} + {1'b0, y};
            OP_SUB:  return {1'b0, x} - {1'b0, y};
            OP_OR:   return {1'b0, x | y};
            OP_LT:   return (x < y) ? 17'h10001 : 17'h00000;
            OP_AND:  return {1'b0, x & y};
            default: return {1'b0, x ^ y};
        endcase
    endfunction

    // Bench ALU: latency 1, NOP leaves outputs unchanged.
    always @(posedge CLK) begin
        if (alu_en && alu_op != OP_NOP) {alu_cf, alu_res} <= alu_f(alu_op, alu_x, alu_y);
    end

    int   cyc = 0;
    always @(posedge CLK) cyc++;

    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    int   rsp_n = 0, en_n = 0;
    int   en_cyc = -100, prev_en_cyc = -100, rv_cyc = -100;
    logic prev_rv = 1'b0, prev_en = 1'b0;
    bit   rv_seen = 1'b0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_rv = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (alu_en) begin
                if (prev_en) check("en_single_cycle", prev_en, 0);
                en_n++;
                prev_en_cyc = en_cyc;
                en_cyc = cyc;
            end
            if (rsp_valid) begin
                rv_seen = 1'b1;
                if (!prev_rv) rv_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_data_cf", {rsp_cf, rsp_data}, mon_e);
                end
                rsp_n++;
            end
            prev_rv = rsp_valid;
            prev_en = alu_en;
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [16:0] e);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_x = x;
        cmd_y = y;
        @(negedge CLK);
        while (!cmd_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) check("push_timeout", cmd_ready, 1);
        else exp_q.push_back(e);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0, r0, n;
        logic [16:0] held;
        logic [15:0] ax;
        logic [2:0]  ops [5];
        logic [15:0] xs [5];
        logic [15:0] ys [5];
        ops = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_ADD};
        xs  = '{16'h1234, 16'h0010, 16'hA000, 16'hFF0F, 16'h8000};
        ys  = '{16'h4321, 16'h0020, 16'h0505, 16'h0FF0, 16'h8000};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_rsp_data", rsp_data, 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Single ADD
        rsp_ready = 1'b1;
        e0 = en_n;
        send(OP_ADD, 16'h0005, 16'h0003, {1'b0, 16'h0008});
        drain(40);
        check("add_en_cycles", en_n - e0, 1);
        check("add_latency", rv_cyc - en_cyc, ALU_LAT + 1);
        check("add_rsp_data", rsp_data, 16'h0008);
        check("add_rsp_cf", rsp_cf, 0);
        check("add_alu_x_held", alu_x, 16'h0005);

        // Overflow ADD
        send(OP_ADD, 16'hFFFF, 16'h0001, {1'b1, 16'h0000});
        drain(40);
        check("ovf_rsp_cf", rsp_cf, 1);
`ifdef ALU_SEQ_OVF_CNT_EN
        check("ovf_cnt", ovf_cnt, 1);
`endif

        // LT then OR back-to-back
        send(OP_LT, 16'h0002, 16'h0007, {1'b1, 16'h0001});
        send(OP_OR, 16'h00F0, 16'h000F, {1'b0, 16'h00FF});
        drain(60);
        check("b2b_spacing", en_cyc - prev_en_cyc, ALU_LAT + 2);
        check("or_latency", rv_cyc - en_cyc, ALU_LAT + 1);
        check("busy_idle", busy, 0);

        // Fill FIFO under response backpressure
        rsp_ready = 1'b0;
        r0 = rsp_n;
        for (int i = 0; i < 5; i++) send(ops[i], xs[i], ys[i], alu_f(ops[i], xs[i], ys[i]));
        check("full_cmd_ready", cmd_ready, 0);
        check("full_busy", busy, 1);
        @(negedge CLK);
        check("bp_valid_start", rsp_valid, 1);
        held = {rsp_cf, rsp_data};
        ax = alu_x;
        e0 = en_n;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp_valid", rsp_valid, 1);
            check("bp_data_cf", {rsp_cf, rsp_data}, held);
            check("bp_alu_en", alu_en, 0);
            check("bp_alu_x", alu_x, ax);
        end
        check("bp_no_issue", en_n - e0, 0);
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        drain(200);
        check("full_rsp_count", rsp_n - r0, 5);
        check("full_cmd_ready_after", cmd_ready, 1);

        // Reset in the middle of WAIT
        rsp_ready = 1'b0;
        send(OP_ADD, 16'h0001, 16'h0001, {1'b0, 16'h0002});
        n = 0;
        @(negedge CLK);
        while (!alu_en && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("rst_reach_issue", alu_en, 1);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_alu_en", alu_en, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu_x", alu_x, 0);
        check("mid_rst_alu_op", alu_op, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_cf", rsp_cf, 0);
`ifdef ALU_SEQ_OVF_CNT_EN
        check("mid_rst_ovf_cnt", ovf_cnt, 0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        rv_seen = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(negedge CLK);
        check("rst_no_rsp", rv_seen, 0);
        check("rst_busy_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
